// File: rtl/run_sequencer.sv
// run_sequencer: runs the latched 8-phase wash programme, counts each phase
// down in time units and drives the valve and motor enables.
module run_sequencer #(
    parameter int unsigned TICKS_PER_UNIT = 50_000_000
) (
    input  logic        cp,
    input  logic        rst_n,
    input  logic [2:0]  state,
    input  logic [25:0] data,
    output logic [3:0]  phase,
    output logic [3:0]  remain,
    output logic [6:0]  total_remain,
    output logic        valve_in,
    output logic        valve_out,
    output logic        motor_wash,
    output logic        motor_spin,
    output logic        busy,
    output logic        done
);
    localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;

    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;
    localparam logic [2:0] ST_PAUSE = 3'd5;

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] FILL1  = 4'd1;
    localparam logic [3:0] WASH   = 4'd2;
    localparam logic [3:0] DRAIN1 = 4'd3;
    localparam logic [3:0] SPIN1  = 4'd4;
    localparam logic [3:0] FILL2  = 4'd5;
    localparam logic [3:0] RINSE  = 4'd6;
    localparam logic [3:0] DRAIN2 = 4'd7;
    localparam logic [3:0] SPIN2  = 4'd8;

    // Duration field belonging to a phase; IDLE has no field.
    function automatic logic [3:0] field_of(input logic [25:0] w, input logic [3:0] p);
        case (p)
            FILL1:   field_of = {1'b0, w[25:23]};
            WASH:    field_of = w[22:19];
            DRAIN1:  field_of = {1'b0, w[18:16]};
            SPIN1:   field_of = {1'b0, w[15:13]};
            FILL2:   field_of = {1'b0, w[12:10]};
            RINSE:   field_of = w[9:6];
            DRAIN2:  field_of = {1'b0, w[5:3]};
            SPIN2:   field_of = {1'b0, w[2:0]};
            default: field_of = 4'd0;
        endcase
    endfunction

    // First phase after cur whose field is nonzero, IDLE if none remain.
    function automatic logic [3:0] next_after(input logic [25:0] w, input logic [3:0] cur);
        next_after = IDLE;
        for (int i = 8; i >= 1; i--)
            if (4'(i) > cur && field_of(w, 4'(i)) != 4'd0) next_after = 4'(i);
    endfunction

    function automatic logic [6:0] sum_fields(input logic [25:0] w);
        sum_fields = 7'd0;
        for (int i = 1; i <= 8; i++)
            sum_fields = sum_fields + {3'b000, field_of(w, 4'(i))};
    endfunction

    logic [3:0]    phase_q, phase_d;
    logic [3:0]    remain_q, remain_d;
    logic [6:0]    total_q, total_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [25:0]   word_q, word_d;
    logic [2:0]    prev_q;
    logic          done_q, done_d;

    logic load, unit_evt, run_q;
    logic [3:0] nxt;

    // A fresh entry into run loads the programme; resuming from pause, or from
    // error with a programme still active, continues where it was frozen.
    assign load     = (state == ST_RUN) &&
                      !(prev_q == ST_RUN || prev_q == ST_PAUSE ||
                        (prev_q == ST_ERR && phase_q != IDLE));
    assign unit_evt = (presc_q == PW'(TICKS_PER_UNIT - 1));
    assign nxt      = next_after(word_q, phase_q);

    // State register: phase FSM plus its counters and the latched word.
    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= IDLE;
            remain_q <= 4'd0;
            total_q  <= 7'd0;
            presc_q  <= '0;
            word_q   <= 26'd0;
            prev_q   <= 3'd0;
            done_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            remain_q <= remain_d;
            total_q  <= total_d;
            presc_q  <= presc_d;
            word_q   <= word_d;
            prev_q   <= state;
            done_q   <= done_d;
        end
    end

    // Next-state: load, count down / advance, abort, or hold (pause/error).
    always_comb begin
        phase_d  = phase_q;
        remain_d = remain_q;
        total_d  = total_q;
        presc_d  = presc_q;
        word_d   = word_q;
        done_d   = 1'b0;
        if (load) begin
            word_d   = data;
            presc_d  = '0;
            phase_d  = next_after(data, IDLE);
            remain_d = field_of(data, phase_d);
            total_d  = sum_fields(data);
            done_d   = (phase_d == IDLE);
        end else if (state == ST_RUN && phase_q != IDLE) begin
            if (unit_evt) begin
                presc_d = '0;
                if (remain_q == 4'd1) begin
                    phase_d  = nxt;
                    remain_d = field_of(word_q, nxt);
                    total_d  = (nxt == IDLE) ? 7'd0 : total_q - 7'd1;
                    done_d   = (nxt == IDLE);
                end else begin
                    remain_d = remain_q - 4'd1;
                    total_d  = total_q - 7'd1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else if (phase_q != IDLE && state != ST_ERR && state != ST_PAUSE) begin
            phase_d  = IDLE;
            remain_d = 4'd0;
            total_d  = 7'd0;
            presc_d  = '0;
        end
    end

    assign run_q = (prev_q == ST_RUN);

    // Outputs: actuators decode registered phase, gated by registered run.
    always_comb begin
        phase        = phase_q;
        remain       = remain_q;
        total_remain = total_q;
        busy         = (phase_q != IDLE);
        done         = done_q;
        valve_in     = run_q && (phase_q == FILL1 || phase_q == FILL2);
        valve_out    = run_q && (phase_q == DRAIN1 || phase_q == DRAIN2 ||
                                 phase_q == SPIN1  || phase_q == SPIN2);
        motor_wash   = run_q && (phase_q == WASH || phase_q == RINSE);
        motor_spin   = run_q && (phase_q == SPIN1 || phase_q == SPIN2);
    end
endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: a programme-level model (elapsed running cycles
// mapped onto the list of phase durations) checked every cycle, plus
// directed scenarios with hand-computed literals.
module tb_run_sequencer;
    localparam int T = 4;

    logic        cp = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  state = 3'd0;
    logic [25:0] data = 26'd0;
    logic [3:0]  phase, remain;
    logic [6:0]  total_remain;
    logic        valve_in, valve_out, motor_wash, motor_spin, busy, done;

    run_sequencer #(.TICKS_PER_UNIT(T)) dut (
        .cp(cp), .rst_n(rst_n), .state(state), .data(data),
        .phase(phase), .remain(remain), .total_remain(total_remain),
        .valve_in(valve_in), .valve_out(valve_out), .motor_wash(motor_wash),
        .motor_spin(motor_spin), .busy(busy), .done(done)
    );

    always #5 cp = ~cp;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge cp) cyc <= cyc + 1;

    localparam logic [25:0] PROG1 = 26'b011_1010_100_101_011_1000_100_101;
    localparam logic [25:0] PROGW = {3'd3, 4'd10, 19'd0};
    localparam logic [25:0] PROGD = {20'd0, 3'd4, 3'd5};

    // ---------------- model ----------------
    function automatic int fwidth(input int i);
        return (i == 2 || i == 6) ? 4 : 3;
    endfunction

    function automatic int fld(input logic [25:0] w, input int i);
        int pos = 26;
        for (int k = 1; k <= i; k++) pos -= fwidth(k);
        return int'((w >> pos) & ((26'd1 << fwidth(i)) - 26'd1));
    endfunction

    function automatic int fsum(input logic [25:0] w);
        int s = 0;
        for (int i = 1; i <= 8; i++) s += fld(w, i);
        return s;
    endfunction

    logic [25:0] m_word;
    int          m_el;
    logic        m_active, m_done;
    logic [2:0]  m_prev;

    always @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            m_word <= 26'd0; m_el <= 0; m_active <= 1'b0; m_done <= 1'b0; m_prev <= 3'd0;
        end else begin
            m_prev <= state;
            m_done <= 1'b0;
            if (state == 3'd3 && !(m_prev == 3'd3 || m_prev == 3'd5 || (m_prev == 3'd4 && m_active))) begin
                m_word   <= data;
                m_el     <= 0;
                m_active <= (fsum(data) != 0);
                m_done   <= (fsum(data) == 0);
            end else if (m_active && state == 3'd3) begin
                m_el <= m_el + 1;
                if (m_el + 1 == fsum(m_word) * T) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end
            end else if (m_active && state != 3'd4 && state != 3'd5) begin
                m_active <= 1'b0;
            end
        end
    end

    function automatic logic [20:0] model_vec();
        int ph = 0, rm = 0, tot = 0, unit, acc = 0, f;
        logic run;
        if (m_active) begin
            unit = m_el / T;
            for (int i = 1; i <= 8; i++) begin
                f = fld(m_word, i);
                if (ph == 0 && unit < acc + f) begin
                    ph = i;
                    rm = f - (unit - acc);
                end
                acc += f;
            end
            tot = fsum(m_word) - unit;
        end
        run = m_active && (m_prev == 3'd3);
        return {4'(ph), 4'(rm), 7'(tot),
                run && (ph == 1 || ph == 5),
                run && (ph == 3 || ph == 4 || ph == 7 || ph == 8),
                run && (ph == 2 || ph == 6),
                run && (ph == 4 || ph == 8),
                m_active, m_done};
    endfunction

    function automatic logic [20:0] dut_vec();
        return {phase, remain, total_remain, valve_in, valve_out,
                motor_wash, motor_spin, busy, done};
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge cp) begin
        n_chk++;
        if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL model_compare t=%0t got=%h exp=%h", $time, dut_vec(), model_vec());
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Waits for done; reports cycles since load edge and the nonzero phase trail.
    task automatic wait_done(input int t_load, output int dt, output logic [31:0] seen);
        seen = 32'd0;
        dt = -1;
        for (int k = 0; k < 600; k++) begin
            @(negedge cp);
            if (phase != 4'd0 && phase != seen[3:0]) seen = {seen[27:0], phase};
            if (done) begin
                dt = cyc - t_load;
                return;
            end
        end
        n_chk++; n_fail++;
        $display("FAIL wait_done timeout");
    endtask

    task automatic wait_phase(input logic [3:0] ph, input int rm, input string name);
        for (int k = 0; k < 600; k++) begin
            @(negedge cp);
            if (phase == ph && (rm < 0 || int'(remain) == rm)) return;
        end
        n_chk++; n_fail++;
        $display("FAIL %s timeout", name);
    endtask

    task automatic start_prog(input logic [25:0] w, output int t_load);
        @(negedge cp);
        state = 3'd2; data = w;
        @(negedge cp);
        state = 3'd3;
        t_load = cyc + 1;
        @(negedge cp);
    endtask

    task automatic finish_prog();
        @(negedge cp); state = 3'd6;
        @(negedge cp); state = 3'd2;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_load, dt;
        logic [31:0] seen;

        // reset state
        repeat (3) @(negedge cp);
        chk("reset_outputs", {11'd0, dut_vec()}, 32'd0);
        rst_n = 1'b1;

        // full programme
        start_prog(PROG1, t_load);
        chk("p1_phase", phase, 1);
        chk("p1_remain", remain, 3);
        chk("p1_total", total_remain, 42);
        chk("p1_valve_in", valve_in, 1);
        data = 26'h3FF_FFFF;  // must be ignored until next load
        wait_done(t_load, dt, seen);
        chk("p1_runtime", dt, 168);
        chk("p1_order", seen, 32'h1234_5678);
        chk("p1_idle_at_done", phase, 0);
        finish_prog();

        // fill+wash only
        start_prog(PROGW, t_load);
        chk("w_phase", phase, 1);
        chk("w_valve_in", {valve_in, motor_wash}, 2'b10);
        wait_done(t_load, dt, seen);
        chk("w_runtime", dt, 52);
        chk("w_order", seen, 32'h12);
        finish_prog();

        // drain2+spin2 only
        start_prog(PROGD, t_load);
        chk("d_phase", phase, 7);
        chk("d_remain", remain, 4);
        chk("d_valve_out", {valve_out, motor_spin}, 2'b10);
        wait_done(t_load, dt, seen);
        chk("d_runtime", dt, 36);
        chk("d_order", seen, 32'h78);
        finish_prog();

        // pause mid-WASH then error, both resume
        start_prog(PROGW, t_load);
        wait_phase(4'd2, 7, "pause_reach");
        state = 3'd5;
        repeat (5) @(negedge cp);
        chk("pause_remain", remain, 7);
        chk("pause_total", total_remain, 7);
        chk("pause_act_busy", {valve_in, valve_out, motor_wash, motor_spin, busy}, 5'b00001);
        repeat (5) @(negedge cp);
        state = 3'd3;
        repeat (2) @(negedge cp);
        chk("resume_wash", motor_wash, 1);
        state = 3'd4;
        repeat (3) @(negedge cp);
        state = 3'd3;
        wait_done(t_load, dt, seen);
        chk("pause_runtime", dt, 52 + 10 + 3);
        finish_prog();

        // all-zero programme
        start_prog(26'd0, t_load);
        chk("zero_done", {phase, done}, {4'd0, 1'b1});
        @(negedge cp);
        chk("zero_done_pulse", {busy, done}, 2'b00);
        finish_prog();

        // abort mid-RINSE
        start_prog(PROG1, t_load);
        wait_phase(4'd6, -1, "rinse_reach");
        state = 3'd2;
        @(negedge cp);
        chk("abort_idle", {phase, remain, total_remain, done}, 16'd0);
        repeat (3) @(negedge cp);
        chk("abort_no_done", done, 0);

        // async reset mid-SPIN1, release in run reloads
        start_prog(PROG1, t_load);
        wait_phase(4'd4, -1, "spin1_reach");
        chk("spin1_act", {valve_out, motor_spin}, 2'b11);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {11'd0, dut_vec()}, 32'd0);
        @(negedge cp);
        rst_n = 1'b1;
        t_load = cyc + 1;
        @(negedge cp);
        chk("reload_state", {phase, remain, total_remain}, {4'd1, 4'd3, 7'd42});
        wait_done(t_load, dt, seen);
        chk("reload_runtime", dt, 168);
        finish_prog();
        repeat (2) @(negedge cp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
